// File: rtl/bytecode_prefetch.sv
// Bytecode fetch unit: prefetches program bytes into a PC-tagged FIFO.
// Ports: clk/rst, en, mem_* read port, redirect/redirect_pc, instr/pc/valid/ready.
module bytecode_prefetch #(
  parameter int PC_W = 12,
  parameter int DEPTH = 4,
  parameter int MAX_OUTST = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [7:0]      mem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [7:0]      instr,
  output logic [PC_W-1:0] pc,
  output logic            valid,
  input  logic            ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] fetch_q, fetch_d;
  logic [PC_W-1:0] resp_q, resp_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      dat_q [DEPTH];
  logic [PC_W-1:0] tag_q [DEPTH];
  logic            issue, push, pop;

  always_comb begin
    valid = cnt_q != '0;
    instr = dat_q[rd_q];
    pc = tag_q[rd_q];
    mem_addr = fetch_q;
    // Credit rule: stale reads still hold a slot, so a
    // returning byte always finds room in the FIFO.
    mem_req = !rst && en && !redirect
      && (outst_q < OW'(MAX_OUTST))
      && (32'(cnt_q) + 32'(outst_q) < 32'(DEPTH));
    issue = mem_req && mem_gnt;
    pop = valid && ready && !redirect;
    push = 1'b0;

    state_d = state_q;
    fetch_d = fetch_q;
    resp_d = resp_q;
    drop_d = drop_q;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    outst_d = outst_q + OW'(issue) - OW'(mem_rvalid);

    if (redirect) begin
      // No issue here, so outst_d is exactly the
      // number of reads whose data is now stale.
      drop_d = outst_d;
      state_d = (outst_d != '0) ? FLUSH : RUN;
      fetch_d = redirect_pc;
      resp_d = redirect_pc;
      rd_d = wr_q;
      cnt_d = '0;
    end else begin
      if (issue) fetch_d = fetch_q + PC_W'(1);
      unique case (state_q)
        RUN: push = mem_rvalid;
        FLUSH: begin
          if (mem_rvalid) begin
            drop_d = drop_q - OW'(1);
            if (drop_q == OW'(1)) state_d = RUN;
          end
        end
      endcase
      if (push) begin
        wr_d = wr_q + PW'(1);
        resp_d = resp_q + PC_W'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fetch_q <= RESET_PC;
      resp_q <= RESET_PC;
      outst_q <= '0;
      drop_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      resp_q <= resp_d;
      outst_q <= outst_d;
      drop_q <= drop_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      if (push) begin
        dat_q[wr_q] <= mem_rdata;
        tag_q[wr_q] <= resp_q;
      end
    end
  end

endmodule

// File: tb/tb_bytecode_prefetch.sv
// Bench for bytecode_prefetch: ROM model with latency,
// scoreboard of expected {pc, instr} popped on handshakes.
module tb_bytecode_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic [7:0]  instr;
  logic [11:0] pc;
  logic        valid;
  logic        ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct packed {
    logic [11:0] pc;
    logic [7:0]  ins;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [11:0] a;
    int          due;
  } req_t;
  req_t mq[$];

  bytecode_prefetch dut (
    .clk(clk), .rst(rst), .en(en),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr(instr),
    .pc(pc), .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [11:0] a);
    return a[7:0] ^ {4'h0, a[11:8]};
  endfunction

  // In-order memory: response driven lat cycles after issue.
  always @(posedge clk) begin
    if (rst) mq.delete();
    else if (mem_req && mem_gnt)
      mq.push_back('{a: mem_addr, due: cyc + lat});
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata = rom(mq[0].a);
      void'(mq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata = '0;
    end
  end

  task automatic push_exp(input logic [11:0] a);
    sb.push_back({a, rom(a)});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid && ready && !redirect) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: pc=%h instr=%h, required none",
                   pc, instr);
        end else begin
          e = sb.pop_front();
          if (pc !== e.pc || instr !== e.ins) begin
            n_err++;
            $display("FAIL stream: pc=%h instr=%h, required pc=%h instr=%h",
                     pc, instr, e.pc, e.ins);
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++; $display("FAIL rst_valid: got %b, required 0", valid);
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL rst_req: got %b, required 0", mem_req);
    end
    n_cmp++;
    if (instr !== 8'h00) begin
      n_err++; $display("FAIL rst_instr: got %h, required 00", instr);
    end
    n_cmp++;
    if (pc !== 12'h000) begin
      n_err++; $display("FAIL rst_pc: got %h, required 000", pc);
    end
    n_cmp++;
    if (mem_addr !== 12'h000) begin
      n_err++; $display("FAIL rst_addr: got %h, required 000", mem_addr);
    end
  endtask

  task automatic test_stream();
    int k, t_iss, t_val, t_end;
    lat = 1; en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 16; i++) push_exp(12'(i));
    @(posedge clk); #1; rst = 1'b0;
    k = 0; t_iss = -1; t_val = -1; t_end = -1;
    while (k < 100) begin
      @(negedge clk);
      if (t_iss < 0 && mem_req && mem_gnt) t_iss = k;
      if (t_val < 0 && valid) t_val = k;
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        t_end = k;
        break;
      end
      k++;
    end
    ready = 1'b0;
    n_cmp++;
    if (t_val - t_iss != 2) begin
      n_err++;
      $display("FAIL first_latency: got %0d, required 2", t_val - t_iss);
    end
    n_cmp++;
    if (t_end - t_val != 15) begin
      n_err++;
      $display("FAIL throughput: got %0d cycles, required 15", t_end - t_val);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b1 || pc !== 12'h010) begin
        n_err++;
        $display("FAIL hold: valid=%b pc=%h, required 1 010", valid, pc);
      end
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL full_req: got %b, required 0", mem_req);
    end
    n_cmp++;
    if (mq.size() != 0) begin
      n_err++;
      $display("FAIL full_outst: got %0d, required 0", mq.size());
    end
    for (int i = 16; i < 32; i++) push_exp(12'(i));
    @(posedge clk); #1; ready = 1'b1;
    wait_drain(100, ok);
    ready = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL bp_drain: left %0d, required 0", sb.size());
    end
  endtask

  task automatic test_redirect_flight();
    bit ok;
    lat = 3;
    repeat (8) @(posedge clk);
    #1; redirect = 1'b1; redirect_pc = 12'h050;
    @(posedge clk); #1; redirect = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 12'h100; ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(12'h100 + 12'(i));
    @(negedge clk);
    n_cmp++;
    if (mq.size() != 2) begin
      n_err++; $display("FAIL in_flight: got %0d, required 2", mq.size());
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL redir_req: got %b, required 0", mem_req);
    end
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++; $display("FAIL stale_valid: got %b, required 0", valid);
    end
    wait_drain(80, ok);
    ready = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL rf_drain: left %0d, required 0", sb.size());
    end
  endtask

  task automatic test_redirect_collide();
    bit ok;
    logic [11:0] np;
    lat = 1;
    repeat (12) @(posedge clk);
    np = 12'h108;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; ready = 1'b1;
      push_exp(np); np++;
    end
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 12'h200;
    for (int i = 0; i < 8; i++) push_exp(12'h200 + 12'(i));
    @(negedge clk);
    n_cmp++;
    if ({mem_rvalid, valid, ready} !== 3'b111) begin
      n_err++;
      $display("FAIL collide_pre: rvalid/valid/ready=%b%b%b, required 111",
               mem_rvalid, valid, ready);
    end
    n_cmp++;
    if (sb.size() != 8) begin
      n_err++; $display("FAIL collide_sb: got %0d, required 8", sb.size());
    end
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++; $display("FAIL collide_valid: got %b, required 0", valid);
    end
    wait_drain(80, ok);
    ready = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL rc_drain: left %0d, required 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    repeat (4) @(posedge clk);
    #1; redirect = 1'b1; redirect_pc = 12'hFFF; ready = 1'b1;
    push_exp(12'hFFF); push_exp(12'h000);
    push_exp(12'h001); push_exp(12'h002);
    @(posedge clk); #1; redirect = 1'b0;
    wait_drain(60, ok);
    ready = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL wrap_drain: left %0d, required 0", sb.size());
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    repeat (12) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b1 || pc !== 12'h003) begin
      n_err++;
      $display("FAIL pre_rst: valid=%b pc=%h, required 1 003", valid, pc);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++; $display("FAIL mrst_valid: got %b, required 0", valid);
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL mrst_req: got %b, required 0", mem_req);
    end
    n_cmp++;
    if (mem_addr !== 12'h000) begin
      n_err++; $display("FAIL mrst_addr: got %h, required 000", mem_addr);
    end
    for (int i = 0; i < 6; i++) push_exp(12'(i));
    @(posedge clk); #1; rst = 1'b0; ready = 1'b1;
    wait_drain(60, ok);
    ready = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL mrst_drain: left %0d, required 0", sb.size());
    end
    en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_err++; $display("FAIL en_off: got %b, required 0", mem_req);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flight();
    test_redirect_collide();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, required completion");
    $fatal(1, "timeout");
  end

endmodule
